// File: rtl/adc_cap_pkg.sv
// Shared types and constants for the triggered ADC capture buffer.
package adc_cap_pkg;

    localparam int SAMPLE_W = 8;

    localparam logic TRIG_RISE = 1'b0;
    localparam logic TRIG_FALL = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PRE,
        ST_ARMED,
        ST_POST,
        ST_READ,
        ST_DONE
    } cap_state_e;

    function automatic logic level_cross(
        input logic [SAMPLE_W-1:0] prev,
        input logic [SAMPLE_W-1:0] cur,
        input logic [SAMPLE_W-1:0] level,
        input logic                edge_sel
    );
        if (edge_sel == TRIG_RISE) begin
            return (prev < level) && (cur >= level);
        end
        return (prev > level) && (cur <= level);
    endfunction

endpackage

// File: rtl/adc_cap_ram.sv
// Simple dual-port sample RAM: one write port, registered single-cycle read port.
module adc_cap_ram
    import adc_cap_pkg::*;
#(
    parameter int DEPTH_LOG2 = 10
) (
    input  logic                  ad_clk,
    input  logic                  we_i,
    input  logic [DEPTH_LOG2-1:0] waddr_i,
    input  logic [SAMPLE_W-1:0]   wdata_i,
    input  logic                  re_i,
    input  logic [DEPTH_LOG2-1:0] raddr_i,
    output logic [SAMPLE_W-1:0]   rdata_o
);

    logic [SAMPLE_W-1:0] mem_q [2**DEPTH_LOG2];

    always_ff @(posedge ad_clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
        if (re_i) begin
            rdata_o <= mem_q[raddr_i];
        end
    end

endmodule

// File: rtl/adc_trig_capture.sv
// Triggered capture buffer: pre/post-trigger recording into a circular RAM, then valid/ready readout.
// Optional build macro ADC_CAP_DECIM_EN adds the decim port (store one sample every decim+1 cycles).
//
// state | meaning
// IDLE  | waiting for arm
// PRE   | filling PRE_DEPTH history samples, triggers ignored
// ARMED | writing continuously, watching for a trigger
// POST  | writing the post-trigger window
// READ  | streaming the record out, no writes
// DONE  | record delivered, waiting for arm
module adc_trig_capture
    import adc_cap_pkg::*;
#(
    parameter int DEPTH_LOG2 = 10,
    parameter int PRE_DEPTH  = 256
) (
    input  logic                ad_clk,
    input  logic                rst_n,
    input  logic [SAMPLE_W-1:0] ad_data,
    input  logic                arm,
    input  logic [SAMPLE_W-1:0] trig_level,
    input  logic                trig_edge,
    input  logic                force_trig,
`ifdef ADC_CAP_DECIM_EN
    input  logic [7:0]          decim,
`endif
    output logic                busy,
    output logic                done,
    output logic [SAMPLE_W-1:0] rd_data,
    output logic                rd_valid,
    input  logic                rd_ready,
    output logic                rd_last
);

    localparam int DEPTH    = 2**DEPTH_LOG2;
    localparam int POST_LEN = DEPTH - PRE_DEPTH - 1;
    localparam logic [DEPTH_LOG2-1:0] PRE_M1  = DEPTH_LOG2'(PRE_DEPTH - 1);
    localparam logic [DEPTH_LOG2-1:0] PRE_OFS = DEPTH_LOG2'(PRE_DEPTH);
    localparam logic [DEPTH_LOG2-1:0] POST_M1 = DEPTH_LOG2'(POST_LEN - 1);
    localparam logic [DEPTH_LOG2:0]   RD_LEN  = (DEPTH_LOG2 + 1)'(DEPTH);

    cap_state_e              state_q, state_d;
    logic [SAMPLE_W-1:0]     s_cur_q;
    logic [SAMPLE_W-1:0]     s_prev_q, s_prev_d;
    logic [DEPTH_LOG2-1:0]   wptr_q, wptr_d;
    logic [DEPTH_LOG2-1:0]   start_q, start_d;
    logic [DEPTH_LOG2-1:0]   cnt_q, cnt_d;
    logic [DEPTH_LOG2-1:0]   rptr_q, rptr_d;
    logic [DEPTH_LOG2:0]     rd_left_q, rd_left_d;
    logic                    force_pend_q, force_pend_d;
    logic                    ram_vld_q, ram_last_q;
    logic [SAMPLE_W-1:0]     fifo_data_q [2];
    logic                    fifo_last_q [2];
    logic                    fifo_wr_q, fifo_rd_q;
    logic [1:0]              fifo_cnt_q;

    logic                    store, we, issue, force_seen, trig;
    logic                    push, pop;
    logic [1:0]              occ;
    logic [SAMPLE_W-1:0]     ram_rdata;

`ifdef ADC_CAP_DECIM_EN
    logic [7:0] dec_cnt_q, dec_cnt_d;

    assign store = (dec_cnt_q == 8'd0);

    always_comb begin
        dec_cnt_d = store ? decim : dec_cnt_q - 8'd1;
        if (arm && (state_q == ST_IDLE || state_q == ST_DONE)) begin
            dec_cnt_d = 8'd0;
        end
    end

    always_ff @(posedge ad_clk or negedge rst_n) begin
        if (!rst_n) dec_cnt_q <= 8'd0;
        else        dec_cnt_q <= dec_cnt_d;
    end
`else
    assign store = 1'b1;
`endif

    // A force pulse landing between stored samples is held until the next one.
    assign force_seen   = force_trig | force_pend_q;
    assign force_pend_d = (state_q == ST_ARMED) && force_seen && !store;
    assign trig         = store && (force_seen ||
                          level_cross(s_prev_q, s_cur_q, trig_level, trig_edge));

    assign push = ram_vld_q;
    assign pop  = rd_valid && rd_ready;
    assign occ  = fifo_cnt_q + {1'b0, ram_vld_q} - {1'b0, pop};

    always_comb begin
        state_d   = state_q;
        s_prev_d  = s_prev_q;
        wptr_d    = wptr_q;
        start_d   = start_q;
        cnt_d     = cnt_q;
        rptr_d    = rptr_q;
        rd_left_d = rd_left_q;
        we        = 1'b0;
        issue     = 1'b0;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (arm) begin
                    state_d = ST_PRE;
                    wptr_d  = '0;
                    start_d = '0;
                    cnt_d   = PRE_M1;
                end
            end
            ST_PRE: begin
                if (store) begin
                    we       = 1'b1;
                    wptr_d   = wptr_q + 1'b1;
                    s_prev_d = s_cur_q;
                    if (cnt_q == '0) state_d = ST_ARMED;
                    else             cnt_d   = cnt_q - 1'b1;
                end
            end
            ST_ARMED: begin
                if (store) begin
                    we       = 1'b1;
                    wptr_d   = wptr_q + 1'b1;
                    s_prev_d = s_cur_q;
                    if (trig) begin
                        start_d = wptr_q - PRE_OFS;
                        if (POST_LEN == 0) begin
                            state_d   = ST_READ;
                            rptr_d    = wptr_q - PRE_OFS;
                            rd_left_d = RD_LEN;
                        end else begin
                            state_d = ST_POST;
                            cnt_d   = POST_M1;
                        end
                    end
                end
            end
            ST_POST: begin
                if (store) begin
                    we       = 1'b1;
                    wptr_d   = wptr_q + 1'b1;
                    s_prev_d = s_cur_q;
                    if (cnt_q == '0) begin
                        state_d   = ST_READ;
                        rptr_d    = start_q;
                        rd_left_d = RD_LEN;
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end
            end
            ST_READ: begin
                // Keep FIFO entries plus the in-flight RAM read within two slots.
                issue = (rd_left_q != '0) && (occ < 2'd2);
                if (issue) begin
                    rptr_d    = rptr_q + 1'b1;
                    rd_left_d = rd_left_q - 1'b1;
                end
                if (pop && rd_last) state_d = ST_DONE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge ad_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            s_cur_q      <= '0;
            s_prev_q     <= '0;
            wptr_q       <= '0;
            start_q      <= '0;
            cnt_q        <= '0;
            rptr_q       <= '0;
            rd_left_q    <= '0;
            force_pend_q <= 1'b0;
            ram_vld_q    <= 1'b0;
            ram_last_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            s_cur_q      <= ad_data;
            s_prev_q     <= s_prev_d;
            wptr_q       <= wptr_d;
            start_q      <= start_d;
            cnt_q        <= cnt_d;
            rptr_q       <= rptr_d;
            rd_left_q    <= rd_left_d;
            force_pend_q <= force_pend_d;
            ram_vld_q    <= issue;
            ram_last_q   <= issue && (rd_left_q == (DEPTH_LOG2 + 1)'(1));
        end
    end

    always_ff @(posedge ad_clk or negedge rst_n) begin
        if (!rst_n) begin
            fifo_data_q[0] <= '0;
            fifo_data_q[1] <= '0;
            fifo_last_q[0] <= 1'b0;
            fifo_last_q[1] <= 1'b0;
            fifo_wr_q      <= 1'b0;
            fifo_rd_q      <= 1'b0;
            fifo_cnt_q     <= 2'd0;
        end else begin
            if (push) begin
                fifo_data_q[fifo_wr_q] <= ram_rdata;
                fifo_last_q[fifo_wr_q] <= ram_last_q;
                fifo_wr_q              <= ~fifo_wr_q;
            end
            if (pop) begin
                fifo_rd_q <= ~fifo_rd_q;
            end
            fifo_cnt_q <= fifo_cnt_q + {1'b0, push} - {1'b0, pop};
        end
    end

    assign rd_valid = (fifo_cnt_q != 2'd0);
    assign rd_data  = fifo_data_q[fifo_rd_q];
    assign rd_last  = rd_valid && fifo_last_q[fifo_rd_q];
    assign busy     = (state_q == ST_PRE) || (state_q == ST_ARMED) ||
                      (state_q == ST_POST) || (state_q == ST_READ);
    assign done     = (state_q == ST_DONE);

    adc_cap_ram #(
        .DEPTH_LOG2(DEPTH_LOG2)
    ) u_ram (
        .ad_clk  (ad_clk),
        .we_i    (we),
        .waddr_i (wptr_q),
        .wdata_i (s_cur_q),
        .re_i    (issue),
        .raddr_i (rptr_q),
        .rdata_o (ram_rdata)
    );

endmodule

// File: tb/tb_adc_trig_capture.sv
// Directed self-checking bench for adc_trig_capture with a 16-sample record and 4-sample pre-window.
module tb_adc_trig_capture;

    logic       ad_clk = 1'b0;
    logic       rst_n  = 1'b0;
    logic [7:0] ad_data = 8'd0;
    logic       arm = 1'b0;
    logic [7:0] trig_level = 8'd0;
    logic       trig_edge = 1'b0;
    logic       force_trig = 1'b0;
    logic       rd_ready = 1'b1;
`ifdef ADC_CAP_DECIM_EN
    logic [7:0] decim = 8'd0;
`endif
    logic       busy, done, rd_valid, rd_last;
    logic [7:0] rd_data;

    logic [7:0] ramp_step = 8'd1;
    int         n_cmp = 0;
    int         n_err = 0;

    always #5 ad_clk = ~ad_clk;

    adc_trig_capture #(
        .DEPTH_LOG2(4),
        .PRE_DEPTH (4)
    ) dut (
        .ad_clk     (ad_clk),
        .rst_n      (rst_n),
        .ad_data    (ad_data),
        .arm        (arm),
        .trig_level (trig_level),
        .trig_edge  (trig_edge),
        .force_trig (force_trig),
`ifdef ADC_CAP_DECIM_EN
        .decim      (decim),
`endif
        .busy       (busy),
        .done       (done),
        .rd_data    (rd_data),
        .rd_valid   (rd_valid),
        .rd_ready   (rd_ready),
        .rd_last    (rd_last)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge ad_clk);
        #1;
        ad_data = ad_data + ramp_step;
    endtask

    task automatic do_arm(input logic [7:0] first_val);
        ad_data = first_val;
        arm = 1'b1;
        tick();
        arm = 1'b0;
    endtask

    task automatic check_idle_outputs(input string tag);
        chk({tag, "_busy"},    busy,     0);
        chk({tag, "_done"},    done,     0);
        chk({tag, "_valid"},   rd_valid, 0);
        chk({tag, "_data"},    rd_data,  0);
        chk({tag, "_last"},    rd_last,  0);
    endtask

    task automatic read_record(input logic [7:0] first, input logic [7:0] step,
                               input bit random_ready, input string tag);
        int         n;
        int         cyc;
        logic [7:0] exp;
        logic       stalled;
        logic [7:0] held;
        n = 0;
        cyc = 0;
        exp = first;
        stalled = 1'b0;
        held = 8'd0;
        while (n < 16 && cyc < 400) begin
            rd_ready = random_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            if (stalled) begin
                chk({tag, "_hold_valid"}, rd_valid, 1);
                chk({tag, "_hold_data"},  rd_data,  held);
            end
            if (rd_valid && rd_ready) begin
                chk({tag, "_data"}, rd_data, exp);
                chk({tag, "_last"}, rd_last, (n == 15) ? 1 : 0);
                exp = exp + step;
                n++;
            end
            stalled = rd_valid && !rd_ready;
            held = rd_data;
            tick();
            cyc++;
        end
        rd_ready = 1'b1;
        chk({tag, "_count"},      n,        16);
        chk({tag, "_done"},       done,     1);
        chk({tag, "_busy_low"},   busy,     0);
        chk({tag, "_valid_low"},  rd_valid, 0);
    endtask

    initial begin
        int wait_cyc;

        #12;
        check_idle_outputs("reset");
        rst_n = 1'b1;
        tick();

        // Rising trigger on an ascending ramp.
        ramp_step = 8'd1;
        trig_level = 8'd100;
        trig_edge = 1'b0;
        do_arm(8'd80);
        chk("rise_busy_after_arm", busy, 1);
        read_record(8'd96, 8'd1, 1'b0, "rise");

        // Falling trigger on a descending ramp.
        ramp_step = 8'hFF;
        trig_level = 8'd50;
        trig_edge = 1'b1;
        do_arm(8'd200);
        read_record(8'd54, 8'hFF, 1'b0, "fall");

        // Forced trigger: pulse in PRE ignored, pulse in ARMED captures.
        ramp_step = 8'd0;
        trig_level = 8'h80;
        trig_edge = 1'b0;
        do_arm(8'h20);
        force_trig = 1'b1;
        tick();
        force_trig = 1'b0;
        repeat (40) tick();
        chk("force_pre_busy",  busy,     1);
        chk("force_pre_done",  done,     0);
        chk("force_pre_valid", rd_valid, 0);
        force_trig = 1'b1;
        tick();
        force_trig = 1'b0;
        read_record(8'h20, 8'd0, 1'b0, "force");

        // Random backpressure.
        ramp_step = 8'd1;
        trig_level = 8'd150;
        trig_edge = 1'b0;
        do_arm(8'd120);
        read_record(8'd146, 8'd1, 1'b1, "bp");

        // Reset in the middle of POST.
        trig_level = 8'd100;
        do_arm(8'd80);
        repeat (25) tick();
        chk("mid_post_busy", busy, 1);
        #3;
        rst_n = 1'b0;
        #1;
        check_idle_outputs("rst_post");
        tick();
        rst_n = 1'b1;
        tick();

        // Reset in the middle of READ while stalled.
        rd_ready = 1'b0;
        do_arm(8'd80);
        wait_cyc = 0;
        while (!rd_valid && wait_cyc < 100) begin
            tick();
            wait_cyc++;
        end
        repeat (3) tick();
        chk("mid_read_valid", rd_valid, 1);
        chk("mid_read_data",  rd_data,  96);
        #3;
        rst_n = 1'b0;
        #1;
        check_idle_outputs("rst_read");
        tick();
        rst_n = 1'b1;
        rd_ready = 1'b1;
        tick();

        // Fresh capture after reset.
        do_arm(8'd80);
        read_record(8'd96, 8'd1, 1'b0, "after_rst");

`ifdef ADC_CAP_DECIM_EN
        decim = 8'd1;
        trig_level = 8'd100;
        do_arm(8'd80);
        read_record(8'd92, 8'd2, 1'b0, "decim");
        decim = 8'd0;
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/adc_trig_capture.md
# adc_trig_capture

- Triggered sample-capture buffer sitting directly downstream of the ADC front end, in the `ad_clk` domain.
- Continuously writes 8-bit `ad_data` into a circular RAM once armed and keeps a programmable pre-trigger history.
- On a level/edge trigger or a forced trigger it completes the post-trigger window, then streams the full record out over a valid/ready port to the processing/display chain.

## Interface
- `DEPTH_LOG2`, 10 — record length is 2^DEPTH_LOG2 samples (1024).
- `PRE_DEPTH`, 256 — samples kept before the trigger sample; legal range 1 .. 2^DEPTH_LOG2-1.
- `ad_clk` in 1 — sample clock; the only clock.
- `rst_n` in 1 — reset, asynchronous and active-low.
- `ad_data` in 8 — raw unsigned ADC sample.
- `arm` in 1 — single-cycle pulse that starts a capture.
- `trig_level` in 8 — unsigned trigger threshold.
- `trig_edge` in 1 — 0 selects a rising crossing, 1 selects a falling crossing.
- `force_trig` in 1 — forces a trigger while ARMED.
- `busy` out 1 — high in PRE, ARMED, POST and READ.
- `done` out 1 — high in DONE.
- `rd_data` out 8 — readout sample.
- `rd_valid` out 1 — readout valid.
- `rd_ready` in 1 — readout ready.
- `rd_last` out 1 — marks the final sample of the record.
- `decim` in 8 — present only with `ADC_CAP_DECIM_EN`.

## Operation
- **Input stage:** `ad_data` is registered once into `s_cur`; the previous stored sample is held in `s_prev`.
- **Reset values:** all outputs 0, state IDLE, write/read pointers 0.
- **FSM states:** IDLE, PRE, ARMED, POST, READ, DONE.
- **IDLE / DONE:**
  - `arm` goes to PRE and clears `done`.
  - Write pointer and `start_addr` are latched to 0.
- **PRE:**
  - Every stored sample is written at `wptr`; `wptr` increments and wraps modulo 2^DEPTH_LOG2.
  - After PRE_DEPTH writes, go to ARMED.
  - Triggers and `force_trig` are ignored.
- **ARMED:**
  - Writing continues.
  - Rising trigger: `s_prev < trig_level` and `s_cur >= trig_level`.
  - Falling trigger: `s_prev > trig_level` and `s_cur <= trig_level`.
  - `force_trig` counts as a trigger on the current sample; a simultaneous real trigger has the same effect.
  - The trigger sample is written at `wptr`.
  - `start_addr` = `wptr` - PRE_DEPTH (mod 2^DEPTH_LOG2); go to POST.
- **POST:**
  - Write a further 2^DEPTH_LOG2 - PRE_DEPTH - 1 samples, then go to READ.
  - `s_prev` always reflects the last written sample.
- **READ:**
  - Emit exactly 2^DEPTH_LOG2 samples from `start_addr`, wrapping.
  - Order: oldest pre-trigger sample first; the trigger sample is at index PRE_DEPTH.
  - No writes occur.
  - After the handshake carrying `rd_last`, go to DONE.
- **Stale data:** any wrap in ARMED overwrites the oldest history. The pre-window always holds the PRE_DEPTH samples immediately before the trigger.
- **Ignored commands:** `arm` in PRE, ARMED, POST or READ is ignored.
- **Reset mid-operation:** asynchronous return to IDLE; any partial readout is abandoned and `rd_valid` drops immediately.

## Timing
- `busy` rises the cycle after `arm` is sampled.
- Trigger decision uses `s_cur`, i.e. `ad_data` delayed by 1 cycle.
- Trigger to READ entry: 2^DEPTH_LOG2 - PRE_DEPTH cycles (undecimated).
- RAM read latency is 1 cycle.
  - `rd_valid` first asserts 2 cycles after READ entry.
  - A 2-entry prefetch allows one sample per cycle when `rd_ready` is held high.
- Handshake rules:
  - A transfer occurs when `rd_valid & rd_ready`.
  - While `rd_valid & !rd_ready`, `rd_data` and `rd_last` are held stable.
  - `rd_valid` never deasserts without a transfer, except on reset.
- `done` rises the cycle after the last transfer; `busy` falls on the same edge.

## Configuration
- Macro `ADC_CAP_DECIM_EN`.
- **Defined:**
  - Port `decim` exists; a decimation counter stores one sample every `decim`+1 cycles.
  - `decim`=0 stores every sample.
  - Trigger evaluation, PRE/POST counts and `s_prev` all operate on stored samples only.
  - The counter restarts at `arm`.
- **Undefined:** no `decim` port; every cycle stores a sample.

## Structure
- Package `adc_cap_pkg`:
  - FSM state enum.
  - Edge constants `TRIG_RISE`=0 and `TRIG_FALL`=1.
  - Sample width constant 8.
- Sub-module `adc_cap_ram`: simple dual-port RAM, 2^DEPTH_LOG2 x 8, one write port, registered 1-cycle read port, no reset on the array.

## Test plan
Bench uses DEPTH_LOG2=4, PRE_DEPTH=4, `rd_ready`=1 unless stated.
- **Rising trigger:** ramp `ad_data` 0,1,2,…; `trig_level`=100, `trig_edge`=0; `arm` at ramp value 80 -> readout 96..111 in order; `rd_last` on 111; then `done`=1, `busy`=0.
- **Falling trigger:** descending ramp 200,199,…; `trig_level`=50, `trig_edge`=1 -> readout 54..39; trigger sample 50 at index 4.
- **Forced trigger:** constant `ad_data`=0x20, `trig_level`=0x80; `force_trig` pulse while ARMED -> 16 samples all 0x20; pulse during PRE ignored.
- **Backpressure:** `rd_ready` toggled randomly -> exactly 16 transfers; no duplicate or skipped values; `rd_data` stable while stalled.
- **Reset mid-readout:** `rst_n` low mid-POST or mid-READ -> all outputs 0 immediately; a fresh `arm` afterwards captures correctly.
- **Decimation:** with `ADC_CAP_DECIM_EN`, `decim`=1 on a ramp -> readout contains only even-spaced samples, step 2.
